axi_mem_arbiter: RTL



---
 rtl/axi_mem_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port between the IFU (read-only)
// and the LSU (read/write); one complete transaction is granted at a time.
module axi_mem_arbiter #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 32,
    parameter logic [3:0] IFU_ID = 4'h0,
    parameter logic [3:0] LSU_ID = 4'h1
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                i_ifu_arvalid,
    output logic                o_ifu_arready,
    input  logic [ADDR_W-1:0]   i_ifu_araddr,
    input  logic [7:0]          i_ifu_arlen,
    input  logic [2:0]          i_ifu_arsize,
    input  logic [1:0]          i_ifu_arburst,
    output logic                o_ifu_rvalid,
    input  logic                i_ifu_rready,
    output logic [DATA_W-1:0]   o_ifu_rdata,
    output logic [1:0]          o_ifu_rresp,
    output logic                o_ifu_rlast,

    input  logic                i_lsu_arvalid,
    output logic                o_lsu_arready,
    input  logic [ADDR_W-1:0]   i_lsu_araddr,
    input  logic [7:0]          i_lsu_arlen,
    input  logic [2:0]          i_lsu_arsize,
    input  logic [1:0]          i_lsu_arburst,
    output logic                o_lsu_rvalid,
    input  logic                i_lsu_rready,
    output logic [DATA_W-1:0]   o_lsu_rdata,
    output logic [1:0]          o_lsu_rresp,
    output logic                o_lsu_rlast,

    input  logic                i_lsu_awvalid,
    output logic                o_lsu_awready,
    input  logic [ADDR_W-1:0]   i_lsu_awaddr,
    input  logic [7:0]          i_lsu_awlen,
    input  logic [2:0]          i_lsu_awsize,
    input  logic [1:0]          i_lsu_awburst,
    input  logic                i_lsu_wvalid,
    output logic                o_lsu_wready,
    input  logic [DATA_W-1:0]   i_lsu_wdata,
    input  logic [DATA_W/8-1:0] i_lsu_wstrb,
    input  logic                i_lsu_wlast,
    output logic                o_lsu_bvalid,
    input  logic                i_lsu_bready,
    output logic [1:0]          o_lsu_bresp,

    output logic                o_io_master_awvalid,
    input  logic                i_io_master_awready,
    output logic [3:0]          o_io_master_awid,
    output logic [ADDR_W-1:0]   o_io_master_awaddr,
    output logic [7:0]          o_io_master_awlen,
    output logic [2:0]          o_io_master_awsize,
    output logic [1:0]          o_io_master_awburst,
    output logic                o_io_master_wvalid,
    input  logic                i_io_master_wready,
    output logic [DATA_W-1:0]   o_io_master_wdata,
    output logic [DATA_W/8-1:0] o_io_master_wstrb,
    output logic                o_io_master_wlast,
    input  logic                i_io_master_bvalid,
    output logic                o_io_master_bready,
    input  logic [3:0]          i_io_master_bid,
    input  logic [1:0]          i_io_master_bresp,
    output logic                o_io_master_arvalid,
    input  logic                i_io_master_arready,
    output logic [3:0]          o_io_master_arid,
    output logic [ADDR_W-1:0]   o_io_master_araddr,
    output logic [7:0]          o_io_master_arlen,
    output logic [2:0]          o_io_master_arsize,
    output logic [1:0]          o_io_master_arburst,
    input  logic                i_io_master_rvalid,
    output logic                o_io_master_rready,
    input  logic [3:0]          i_io_master_rid,
    input  logic [DATA_W-1:0]   i_io_master_rdata,
    input  logic [1:0]          i_io_master_rresp,
    input  logic                i_io_master_rlast
);

    typedef enum logic [2:0] {
        IDLE, IFU_RD, LSU_RD, LSU_WR_A, LSU_WR_D, LSU_WR_B
    } state_t;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    state_t r_state;
    state_t w_nextState;
    logic   r_lastGrant;
    logic   r_wlastDone;
    logic   w_grantIfu;
    logic   w_grantLsu;
    logic   w_wlastHs;
    logic   w_lsuReq;
    logic   w_unused;

    // Response IDs are not used for routing: only one transaction is ever in flight.
    assign w_unused = ^{i_io_master_bid, i_io_master_rid};
    assign w_lsuReq = i_lsu_awvalid | i_lsu_arvalid;

    assign o_io_master_arid    = (r_state == LSU_RD) ? LSU_ID        : IFU_ID;
    assign o_io_master_araddr  = (r_state == LSU_RD) ? i_lsu_araddr  : i_ifu_araddr;
    assign o_io_master_arlen   = (r_state == LSU_RD) ? i_lsu_arlen   : i_ifu_arlen;
    assign o_io_master_arsize  = (r_state == LSU_RD) ? i_lsu_arsize  : i_ifu_arsize;
    assign o_io_master_arburst = (r_state == LSU_RD) ? i_lsu_arburst : i_ifu_arburst;

    assign o_io_master_awid    = LSU_ID;
    assign o_io_master_awaddr  = i_lsu_awaddr;
    assign o_io_master_awlen   = i_lsu_awlen;
    assign o_io_master_awsize  = i_lsu_awsize;
    assign o_io_master_awburst = i_lsu_awburst;
    assign o_io_master_wdata   = i_lsu_wdata;
    assign o_io_master_wstrb   = i_lsu_wstrb;
    assign o_io_master_wlast   = i_lsu_wlast;

    assign o_ifu_rdata = i_io_master_rdata;
    assign o_ifu_rresp = i_io_master_rresp;
    assign o_ifu_rlast = i_io_master_rlast;
    assign o_lsu_rdata = i_io_master_rdata;
    assign o_lsu_rresp = i_io_master_rresp;
    assign o_lsu_rlast = i_io_master_rlast;
    assign o_lsu_bresp = i_io_master_bresp;

    always_comb begin
        w_nextState         = r_state;
        w_grantIfu          = 1'b0;
        w_grantLsu          = 1'b0;
        w_wlastHs           = 1'b0;
        o_ifu_arready       = 1'b0;
        o_ifu_rvalid        = 1'b0;
        o_lsu_arready       = 1'b0;
        o_lsu_rvalid        = 1'b0;
        o_lsu_awready       = 1'b0;
        o_lsu_wready        = 1'b0;
        o_lsu_bvalid        = 1'b0;
        o_io_master_awvalid = 1'b0;
        o_io_master_wvalid  = 1'b0;
        o_io_master_bready  = 1'b0;
        o_io_master_arvalid = 1'b0;
        o_io_master_rready  = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the requester not granted last time wins; LSU writes beat LSU reads.
                if (i_ifu_arvalid && (!w_lsuReq || r_lastGrant == GRANT_LSU)) begin
                    w_grantIfu  = 1'b1;
                    w_nextState = IFU_RD;
                end else if (w_lsuReq) begin
                    w_grantLsu  = 1'b1;
                    w_nextState = i_lsu_awvalid ? LSU_WR_A : LSU_RD;
                end
            end
            IFU_RD: begin
                o_io_master_arvalid = i_ifu_arvalid;
                o_ifu_arready       = i_io_master_arready;
                o_ifu_rvalid        = i_io_master_rvalid;
                o_io_master_rready  = i_ifu_rready;
                if (i_io_master_rvalid && i_ifu_rready && i_io_master_rlast)
                    w_nextState = IDLE;
            end
            LSU_RD: begin
                o_io_master_arvalid = i_lsu_arvalid;
                o_lsu_arready       = i_io_master_arready;
                o_lsu_rvalid        = i_io_master_rvalid;
                o_io_master_rready  = i_lsu_rready;
                if (i_io_master_rvalid && i_lsu_rready && i_io_master_rlast)
                    w_nextState = IDLE;
            end
            LSU_WR_A: begin
                // W may run ahead of AW; once its last beat is taken, further W is blocked.
                o_io_master_awvalid = i_lsu_awvalid;
                o_lsu_awready       = i_io_master_awready;
                o_io_master_wvalid  = i_lsu_wvalid & ~r_wlastDone;
                o_lsu_wready        = i_io_master_wready & ~r_wlastDone;
                w_wlastHs           = i_lsu_wvalid & ~r_wlastDone & i_io_master_wready & i_lsu_wlast;
                if (i_lsu_awvalid && i_io_master_awready)
                    w_nextState = (r_wlastDone || w_wlastHs) ? LSU_WR_B : LSU_WR_D;
            end
            LSU_WR_D: begin
                o_io_master_wvalid = i_lsu_wvalid;
                o_lsu_wready       = i_io_master_wready;
                w_wlastHs          = i_lsu_wvalid & i_io_master_wready & i_lsu_wlast;
                if (w_wlastHs)
                    w_nextState = LSU_WR_B;
            end
            LSU_WR_B: begin
                o_lsu_bvalid       = i_io_master_bvalid;
                o_io_master_bready = i_lsu_bready;
                if (i_io_master_bvalid && i_lsu_bready)
                    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_lastGrant <= GRANT_LSU;
            r_wlastDone <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_grantIfu)
                r_lastGrant <= GRANT_IFU;
            else if (w_grantLsu)
                r_lastGrant <= GRANT_LSU;
            if (w_nextState == LSU_WR_A)
                r_wlastDone <= r_wlastDone | w_wlastHs;
            else
                r_wlastDone <= 1'b0;
        end
    end

endmodule
